// File: rtl/id_pkg.sv
// id_pkg: character classes, lexer FSM states and the char classifier shared by id_fsm and id_token_packer
package id_pkg;
  typedef enum logic [1:0] {ILLEGAL = 2'b00, ALPHA = 2'b01, DIGIT = 2'b10} cls_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ALPHA = 2'b01, S_DIGIT = 2'b10} state_t;
  function automatic cls_t classify(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ? DIGIT :
           ((c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a)) ? ALPHA : ILLEGAL;
  endfunction
endpackage

// File: rtl/id_tok_fifo.sv
// id_tok_fifo: synchronous FIFO of DEPTH (power of 2) entries; caller must not push when full without popping
module id_tok_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic pop_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
    if (push) mem_q[wr_q] <= din;
  end
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (AW+1)'(DEPTH);
    pop_ok = pop & ~empty;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop_ok ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop_ok);
    head = mem_q[rd_q];
  end
endmodule

// File: rtl/id_token_packer.sv
// id_token_packer: delimits identifier tokens and queues {length, ends-in-digit} records for a valid/ready consumer
// Define TOK_FIRST_CHAR_EN to also carry each token's first character on tok_first.
module id_token_packer
  import id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 6,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         char,
  input  logic               char_valid,
  input  logic               flush,
  output logic               tok_valid,
  input  logic               tok_ready,
  output logic [LEN_W-1:0]   tok_len,
  output logic               tok_digit,
  output logic               in_ident,
  output logic [COUNT_W-1:0] id_count,
`ifdef TOK_FIRST_CHAR_EN
  output logic [7:0]         tok_first,
`endif
  output logic               overflow
);
`ifdef TOK_FIRST_CHAR_EN
  localparam int W = LEN_W + 9;
  logic [7:0] first_q, first_d;
`else
  localparam int W = LEN_W + 1;
`endif
  state_t state_q, state_d;
  cls_t cls;
  logic [LEN_W-1:0] len_q, len_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic overflow_q, overflow_d, push, push_ok, pop, full, empty;
  logic [W-1:0] hold_q, hold_d, rec, head, word;
  id_tok_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .reset(reset), .push(push_ok), .pop(pop), .din(rec),
    .full(full), .empty(empty), .head(head)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      hold_q <= '0;
`ifdef TOK_FIRST_CHAR_EN
      first_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      hold_q <= hold_d;
`ifdef TOK_FIRST_CHAR_EN
      first_q <= first_d;
`endif
    end
  end
  always_comb begin
    cls = classify(char);
    state_d = flush ? S_IDLE :
              !char_valid ? state_q :
              cls == ALPHA ? S_ALPHA :
              (cls == DIGIT && state_q != S_IDLE) ? S_DIGIT : S_IDLE;
  end
  always_comb begin
    push = (state_q != S_IDLE) & (flush | (char_valid & cls == ILLEGAL));
    len_d = state_d == S_IDLE ? '0 :
            state_q == S_IDLE ? LEN_W'(1) :
            (state_d != state_q || char_valid) && len_q != '1 ? len_q + 1'b1 : len_q;
`ifdef TOK_FIRST_CHAR_EN
    first_d = (state_q == S_IDLE && state_d == S_ALPHA) ? char : first_q;
    rec = {first_q, len_q, state_q == S_DIGIT};
`else
    rec = {len_q, state_q == S_DIGIT};
`endif
    tok_valid = ~empty;
    pop = tok_valid & tok_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push_ok = push & (~full | pop);
    overflow_d = overflow_q | (push & ~push_ok);
    count_d = count_q + COUNT_W'(push_ok);
    hold_d = tok_valid ? head : hold_q;
    word = tok_valid ? head : hold_q;
    tok_len = word[LEN_W:1];
    tok_digit = word[0];
`ifdef TOK_FIRST_CHAR_EN
    tok_first = word[W-1 -: 8];
`endif
    in_ident = state_q != S_IDLE;
    id_count = count_q;
    overflow = overflow_q;
  end
endmodule
